// File: rtl/change_dispenser.sv
// Change/item dispenser downstream of the vending control FSM: releases the item,
// pays greedy change or a refund one coin per handshake, and tracks per-item stock.
module change_dispenser #(
   parameter int COIN0      = 20,
   parameter int COIN1      = 10,
   parameter int COIN2      = 5,
   parameter int COIN3      = 1,
   parameter int STOCK_W    = 4,
   parameter int STOCK_INIT = 3
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       done,
   input  logic       end_trans,
   input  logic [7:0] sum_money,
   input  logic [7:0] price,
   input  logic [1:0] item_select,
   input  logic       item_ack,
   input  logic       coin_ack,
   input  logic       restock,
   input  logic [1:0] restock_item,
   output logic       item_valid,
   output logic [1:0] item_id,
   output logic       coin_valid,
   output logic [1:0] coin_type,
   output logic       busy,
   output logic       disp_done,
   output logic       err,
   output logic [3:0] out_stock
);

   localparam logic [7:0] C0 = 8'(COIN0);
   localparam logic [7:0] C1 = 8'(COIN1);
   localparam logic [7:0] C2 = 8'(COIN2);
   localparam logic [7:0] C3 = 8'(COIN3);

   typedef enum logic [1:0] {IDLE, ITEM, CHANGE, FIN} state_t;

   state_t             state_q;
   logic [7:0]         remaining_q;
   logic [1:0]         item_id_q;
   logic               err_q;
   logic [STOCK_W-1:0] stock_q [4];

   logic [1:0]         coin_sel_d;
   logic [7:0]         coin_amt_d;

   // Greedy pick: largest denomination not exceeding what is still owed.
   always_comb begin
      coin_sel_d = 2'd3;
      coin_amt_d = C3;
      if (remaining_q >= C0) begin
         coin_sel_d = 2'd0;
         coin_amt_d = C0;
      end else if (remaining_q >= C1) begin
         coin_sel_d = 2'd1;
         coin_amt_d = C1;
      end else if (remaining_q >= C2) begin
         coin_sel_d = 2'd2;
         coin_amt_d = C2;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q     <= IDLE;
         remaining_q <= '0;
         item_id_q   <= '0;
         err_q       <= 1'b0;
         for (int unsigned i = 0; i < 4; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
      end else begin
         err_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (done) begin
                  if (sum_money >= price && stock_q[item_select] != '0) begin
                     item_id_q   <= item_select;
                     remaining_q <= sum_money - price;
                     state_q     <= ITEM;
                  end else begin
                     err_q       <= 1'b1;
                     remaining_q <= sum_money;
                     state_q     <= (sum_money != '0) ? CHANGE : FIN;
                  end
               end else if (end_trans) begin
                  remaining_q <= sum_money;
                  state_q     <= (sum_money != '0) ? CHANGE : FIN;
               end
            end
            ITEM: begin
               if (item_ack) begin
                  if (stock_q[item_id_q] != '0)
                     stock_q[item_id_q] <= stock_q[item_id_q] - STOCK_W'(1);
                  state_q <= (remaining_q != '0) ? CHANGE : FIN;
               end
            end
            CHANGE: begin
               if (coin_ack) begin
                  remaining_q <= remaining_q - coin_amt_d;
                  if (remaining_q == coin_amt_d) state_q <= FIN;
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
         // Placed after the case so a refill overrides a same-cycle decrement.
         if (restock) stock_q[restock_item] <= '1;
      end
   end

   assign item_valid = (state_q == ITEM);
   assign item_id    = item_id_q;
   assign coin_valid = (state_q == CHANGE);
   assign coin_type  = coin_valid ? coin_sel_d : 2'd0;
   assign busy       = (state_q != IDLE);
   assign disp_done  = (state_q == FIN);
   assign err        = err_q;

   always_comb begin
      out_stock = '0;
      for (int unsigned i = 0; i < 4; i++) out_stock[i] = (stock_q[i] == '0);
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: expected item/coin/err/done events are queued
// when a transaction is launched and compared against the events the DUT produces.
module tb_change_dispenser;

   logic       clk = 1'b0, reset_n = 1'b0;
   logic       done = 1'b0, end_trans = 1'b0, item_ack = 1'b0, coin_ack = 1'b0, restock = 1'b0;
   logic [7:0] sum_money = '0, price = '0;
   logic [1:0] item_select = '0, restock_item = '0;
   logic       item_valid, coin_valid, busy, disp_done, err;
   logic [1:0] item_id, coin_type;
   logic [3:0] out_stock;

   int n_cmp = 0, n_fail = 0;
   int exp_q[$], obs_q[$], held_q[$];

   // Event codes: 0..3 coin type, 100+id item release, 200 disp_done, 300 err.
   localparam int EV_ITEM = 100, EV_DONE = 200, EV_ERR = 300;

   change_dispenser #(.COIN0(20), .COIN1(10), .COIN2(5), .COIN3(1), .STOCK_W(4), .STOCK_INIT(3)) dut (
      .clk(clk), .reset_n(reset_n), .done(done), .end_trans(end_trans),
      .sum_money(sum_money), .price(price), .item_select(item_select),
      .item_ack(item_ack), .coin_ack(coin_ack), .restock(restock), .restock_item(restock_item),
      .item_valid(item_valid), .item_id(item_id), .coin_valid(coin_valid), .coin_type(coin_type),
      .busy(busy), .disp_done(disp_done), .err(err), .out_stock(out_stock)
   );

   always #5 clk = ~clk;

   task automatic trigger(input logic d, input logic e, input logic [7:0] s, input logic [7:0] p,
                          input logic [1:0] sel);
      @(negedge clk);
      done = d; end_trans = e; sum_money = s; price = p; item_select = sel;
      @(negedge clk);
      done = 1'b0; end_trans = 1'b0;
   endtask

   // Acks every presented item/coin (first coin held off for 'hold' cycles) and logs events.
   task automatic service(input int hold);
      int h = hold;
      bit fin = 1'b0;
      for (int c = 0; c < 200 && !fin; c++) begin
         item_ack = 1'b0; coin_ack = 1'b0;
         if (err) obs_q.push_back(EV_ERR);
         if (disp_done) begin
            obs_q.push_back(EV_DONE);
            fin = 1'b1;
         end else begin
            if (item_valid) begin
               obs_q.push_back(EV_ITEM + int'(item_id));
               item_ack = 1'b1;
            end
            if (coin_valid) begin
               if (h > 0) begin
                  held_q.push_back(int'(coin_type));
                  h--;
               end else begin
                  obs_q.push_back(int'(coin_type));
                  coin_ack = 1'b1;
               end
            end
            @(negedge clk);
         end
      end
      item_ack = 1'b0; coin_ack = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0;
      repeat (2) @(negedge clk);
      n_cmp++;
      if ({item_valid, coin_valid, busy, disp_done, err, item_id, coin_type, out_stock} !== 15'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got iv=%b cv=%b busy=%b dd=%b err=%b id=%0d ct=%0d os=%b, want all 0",
                  item_valid, coin_valid, busy, disp_done, err, item_id, coin_type, out_stock);
      end
      reset_n = 1'b1;
      trigger(1'b0, 1'b1, 8'd35, 8'd0, 2'd0);
      n_cmp++;
      if (coin_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_change: coin_valid=%b, want 1", coin_valid);
      end
      reset_n = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (coin_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_change: coin_valid=%b busy=%b, want 0 0", coin_valid, busy);
      end
      reset_n = 1'b1;
      @(negedge clk);
      n_cmp++;
      if (coin_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_no_resume: coin_valid=%b busy=%b, want 0 0", coin_valid, busy);
      end
   endtask

   task automatic test_purchase;
      int e, o;
      exp_q = '{EV_ITEM + 2, 0, 3, 3, EV_DONE};
      trigger(1'b1, 1'b0, 8'd37, 8'd15, 2'd2);
      service(0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL purchase_len: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL purchase_evt: got %0d, want %0d", o, e);
         end
      end
      obs_q.delete();
      @(negedge clk);
      n_cmp++;
      if (disp_done !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL purchase_done_pulse: disp_done=%b busy=%b, want 0 0", disp_done, busy);
      end
      n_cmp++;
      if (dut.stock_q[2] !== 4'd2) begin
         n_fail++;
         $display("FAIL purchase_stock2: got %0d, want 2", dut.stock_q[2]);
      end
   endtask

   task automatic test_refund_hold;
      int e, o;
      exp_q = '{0, 1, 2, EV_DONE};
      held_q.delete();
      trigger(1'b0, 1'b1, 8'd35, 8'd0, 2'd0);
      service(5);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL refund_len: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL refund_evt: got %0d, want %0d", o, e);
         end
      end
      obs_q.delete();
      n_cmp++;
      if (held_q.size() != 5) begin
         n_fail++;
         $display("FAIL refund_hold_len: got %0d held cycles, want 5", held_q.size());
      end
      foreach (held_q[i]) begin
         n_cmp++;
         if (held_q[i] !== 0) begin
            n_fail++;
            $display("FAIL refund_hold_type: cycle %0d coin_type=%0d, want 0", i, held_q[i]);
         end
      end
   endtask

   task automatic test_exact;
      int e, o;
      exp_q = '{EV_ITEM + 0, EV_DONE};
      trigger(1'b1, 1'b0, 8'd10, 8'd10, 2'd0);
      service(0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL exact_len: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL exact_evt: got %0d, want %0d", o, e);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_underpay;
      int e, o;
      exp_q = '{EV_ERR, 3, 3, 3, 3, EV_DONE};
      trigger(1'b1, 1'b0, 8'd4, 8'd10, 2'd3);
      service(0);
      n_cmp++;
      if (obs_q.size() != exp_q.size()) begin
         n_fail++;
         $display("FAIL underpay_len: got %0d events, want %0d", obs_q.size(), exp_q.size());
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
         n_cmp++;
         if (o !== e) begin
            n_fail++;
            $display("FAIL underpay_evt: got %0d, want %0d", o, e);
         end
      end
      obs_q.delete();
   endtask

   task automatic test_out_of_stock;
      int e, o;
      for (int k = 0; k < 4; k++) begin
         if (k < 3) exp_q = '{EV_ITEM + 1, EV_DONE};
         else       exp_q = '{EV_ERR, 0, EV_DONE};
         trigger(1'b1, 1'b0, (k < 3) ? 8'd10 : 8'd20, 8'd10, 2'd1);
         service(0);
         n_cmp++;
         if (obs_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL oos_len[%0d]: got %0d events, want %0d", k, obs_q.size(), exp_q.size());
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = (obs_q.size() > 0) ? obs_q.pop_front() : -1;
            n_cmp++;
            if (o !== e) begin
               n_fail++;
               $display("FAIL oos_evt[%0d]: got %0d, want %0d", k, o, e);
            end
         end
         obs_q.delete();
         if (k == 2) begin
            @(negedge clk);
            n_cmp++;
            if (out_stock !== 4'b0010) begin
               n_fail++;
               $display("FAIL oos_flag: out_stock=%b, want 0010", out_stock);
            end
         end
      end
      @(negedge clk);
      restock = 1'b1; restock_item = 2'd1;
      @(negedge clk);
      restock = 1'b0;
      n_cmp++;
      if (out_stock !== 4'b0000) begin
         n_fail++;
         $display("FAIL restock_flag: out_stock=%b, want 0000", out_stock);
      end
      n_cmp++;
      if (dut.stock_q[1] !== 4'd15) begin
         n_fail++;
         $display("FAIL restock_count: stock[1]=%0d, want 15", dut.stock_q[1]);
      end
   endtask

   initial begin
      test_reset();
      test_purchase();
      test_refund_hold();
      test_exact();
      test_underpay();
      test_out_of_stock();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, compared=%0d mismatched=%0d", n_cmp, n_fail);
      $fatal(1, "watchdog expired");
   end

endmodule
